uart_prog_loader: RTL and testbench
===================================

Name: uart_prog_loader

Overview:
- Sits between the UART byte receiver and the instruction memory / core inside full_cpu.
- Consumes received bytes, frames them into 24-bit instruction words and writes them to consecutive instruction-memory addresses.
- Holds the core halted while a program is loading, then optionally pulses core reset on the stop word.
- Framing: start word 0xFF0000; stop words 0xFFFF00 (run) and 0xFFFF01 (hold). Bytes arrive LSB byte first; word = {byte2, byte1, byte0}.

Parameters:
- ADDR_W, 8, instruction memory address width; capacity 2^ADDR_W words.
- RST_PULSE_CYCLES, 16, width of cpu_rst pulse in clk cycles (>=1).
- TIMEOUT_CYCLES, 100000, inter-byte gap that discards a partial word (only with LOADER_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous active-high reset
- rx_valid  in  1  single-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  24  instruction word
- cpu_hold  out  1  core halted (held in reset) while loading
- cpu_rst  out  1  core reset pulse after stop-run
- load_active  out  1  high in LOAD state
- word_count  out  ADDR_W+1  words written in the current/last load
- load_err  out  1  sticky overflow/timeout flag, cleared on next start word

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; byte shift register 0x000000; byte index 0; pulse counter 0.
- IDLE:
  - Sliding 3-byte window: each rx_valid shifts rx_data in as the new MSB byte.
  - When the window equals 0xFF0000 (bytes 00,00,FF): go to LOAD.
  - On that transition: imem_addr=0, word_count=0, load_err=0, byte index=0, cpu_hold=1 from the next cycle.
  - Sliding detection resynchronises on arbitrary leading garbage.
- LOAD:
  - Aligned 3-byte assembly with byte index 0,1,2.
  - On the third byte, the assembled word W is decoded:
    - W=0xFF0000: restart. imem_addr and word_count return to 0, no write.
    - W=0xFFFF00: stop-run. No write; state IDLE; cpu_hold=0 next cycle; cpu_rst=1 for exactly RST_PULSE_CYCLES cycles starting the same cycle cpu_hold falls.
    - W=0xFFFF01: stop-hold. No write; state IDLE; cpu_hold stays 1 until the next stop-run or rst.
    - Otherwise: imem_we=1 for one cycle, registered, the cycle after the third rx_valid. imem_wdata=W, imem_addr=current address. The address increments after the write.
  - Latency: third rx_valid at edge N -> imem_we high during cycle N+1.
- Overflow:
  - A word is written while the address is 2^ADDR_W-1: address saturates, further data words are dropped and load_err=1.
  - word_count saturates at 2^ADDR_W.
- Data stays data: a data word equal to 0x000000 or 0xFF00FD etc. is written normally. Only the exact three control words are special.
- rx_valid during an active cpu_rst pulse: processed normally. A start word restarts loading and aborts the pulse (cpu_rst=0, cpu_hold=1 next cycle).
- rx_valid while imem_we is high: accepted; byte index continues.
- Reset mid-load: everything returns to IDLE immediately. Partial word discarded; memory contents untouched.
- load_active = (state==LOAD).

Optional Feature:
- Macro LOADER_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in LOAD while byte index != 0 and clears on each rx_valid.
  - On reaching TIMEOUT_CYCLES: byte index returns to 0, partial bytes are discarded and load_err=1. State remains LOAD.
- Undefined: no counter is built. Partial words wait indefinitely and the TIMEOUT_CYCLES parameter is unused.

Test Plan:
- Bytes 00,00,FF then 0A,01,80 then 14,02,80 then 00,FF,FF -> start detected; writes 0x80010A@0 and 0x800214@1, each with imem_we one cycle after the third byte; cpu_hold falls; cpu_rst high exactly 16 cycles; word_count=2.
- Garbage 37,00,00,FF then 05,04,80 then 01,FF,FF -> sliding sync finds start; 0x800405@0 written; stop-hold leaves cpu_hold=1 and cpu_rst never asserts.
- ADDR_W=2 with start + 5 data words + stop-run -> addresses 0..3 written; fifth word dropped; load_err=1; word_count=4.
- Start, 2 data words, start, 1 data word 0xD400FD (FD,00,D4), stop-run -> last write targets address 0; word_count=1.
- rst pulsed after the second byte of a data word, then start + 00,13,03 + stop-run -> no write before the restart; 0x031300@0.
- With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=1000: start, bytes 0A,01, 2000-cycle gap, then 32,06,80 -> load_err=1; single write 0x800632@0.

Source files
------------

// File: rtl/uart_prog_loader.sv
// UART program loader: frames received bytes into 24-bit words, writes them to instruction
// memory and sequences core hold/reset. Optional inter-byte timeout: define LOADER_TIMEOUT_EN.
module uart_prog_loader #(
  parameter int unsigned ADDR_W           = 8,
  parameter int unsigned RST_PULSE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES   = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [23:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              cpu_rst,
  output logic              load_active,
  output logic [ADDR_W:0]   word_count,
  output logic              load_err
);

  localparam logic [23:0] START_WORD = 24'hFF0000;
  localparam logic [23:0] STOP_RUN   = 24'hFFFF00;
  localparam logic [23:0] STOP_HOLD  = 24'hFFFF01;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam int PCW = $clog2(RST_PULSE_CYCLES + 1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t             state, state_nxt;
  logic [15:0]        hist, hist_nxt;
  logic [1:0]         byte_idx, byte_idx_nxt;
  logic [PCW-1:0]     pulse_cnt, pulse_cnt_nxt;
  logic               imem_we_nxt, cpu_hold_nxt, cpu_rst_nxt, load_err_nxt;
  logic [ADDR_W-1:0]  imem_addr_nxt;
  logic [23:0]        imem_wdata_nxt;
  logic [ADDR_W:0]    word_count_nxt;

  // hist holds the two previous bytes; with the incoming byte it forms both the
  // sliding start-detect window in IDLE and the aligned word in LOAD.
  logic [23:0] window;
  logic        word_done, start_hit, mem_full;

  assign window    = {rx_data, hist};
  assign word_done = rx_valid && (state == LOAD) && (byte_idx == 2'd2);
  assign start_hit = ((rx_valid && (state == IDLE)) || word_done) && (window == START_WORD);
  // word_count reaches 2^ADDR_W exactly when the last address has been written.
  assign mem_full  = word_count[ADDR_W];
  assign load_active = (state == LOAD);

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer, timer_nxt;
`endif

  // NOTE: every signal assigned below gets its hold value first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    hist_nxt       = hist;
    byte_idx_nxt   = byte_idx;
    pulse_cnt_nxt  = pulse_cnt;
    imem_we_nxt    = 1'b0;
    imem_addr_nxt  = imem_addr;
    imem_wdata_nxt = imem_wdata;
    word_count_nxt = word_count;
    cpu_hold_nxt   = cpu_hold;
    cpu_rst_nxt    = cpu_rst;
    load_err_nxt   = load_err;

    // Address advances in the cycle the write is presented, saturating at the top.
    if (imem_we && (imem_addr != ADDR_MAX)) imem_addr_nxt = imem_addr + 1'b1;

    if (cpu_rst) begin
      if (pulse_cnt == '0) cpu_rst_nxt = 1'b0;
      else                 pulse_cnt_nxt = pulse_cnt - 1'b1;
    end

`ifdef LOADER_TIMEOUT_EN
    timer_nxt = '0;
    if ((state == LOAD) && (byte_idx != 2'd0) && !rx_valid) begin
      if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
        byte_idx_nxt = 2'd0;
        load_err_nxt = 1'b1;
      end else begin
        timer_nxt = timer + 1'b1;
      end
    end
`endif

    if (rx_valid) begin
      hist_nxt = {rx_data, hist[15:8]};
      if (state == LOAD) byte_idx_nxt = (byte_idx == 2'd2) ? 2'd0 : byte_idx + 1'b1;
    end

    if (start_hit) begin
      state_nxt      = LOAD;
      imem_addr_nxt  = '0;
      word_count_nxt = '0;
      load_err_nxt   = 1'b0;
      byte_idx_nxt   = 2'd0;
      cpu_hold_nxt   = 1'b1;
      cpu_rst_nxt    = 1'b0;
      pulse_cnt_nxt  = '0;
    end else if (word_done) begin
      if (window == STOP_RUN) begin
        state_nxt     = IDLE;
        cpu_hold_nxt  = 1'b0;
        cpu_rst_nxt   = 1'b1;
        pulse_cnt_nxt = PCW'(RST_PULSE_CYCLES - 1);
      end else if (window == STOP_HOLD) begin
        state_nxt = IDLE;
      end else if (mem_full) begin
        load_err_nxt = 1'b1;
      end else begin
        imem_we_nxt    = 1'b1;
        imem_wdata_nxt = window;
        word_count_nxt = word_count + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hist       <= '0;
      byte_idx   <= 2'd0;
      pulse_cnt  <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      cpu_hold   <= 1'b0;
      cpu_rst    <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      hist       <= hist_nxt;
      byte_idx   <= byte_idx_nxt;
      pulse_cnt  <= pulse_cnt_nxt;
      imem_we    <= imem_we_nxt;
      imem_addr  <= imem_addr_nxt;
      imem_wdata <= imem_wdata_nxt;
      word_count <= word_count_nxt;
      cpu_hold   <= cpu_hold_nxt;
      cpu_rst    <= cpu_rst_nxt;
      load_err   <= load_err_nxt;
    end
  end

`ifdef LOADER_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer <= '0;
    else     timer <= timer_nxt;
  end
`endif

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: a default-size instance plus an ADDR_W=2 instance
// for overflow; expected writes are queued as bytes are driven and popped on imem_we.
module tb_uart_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;

  logic        imem_we, cpu_hold, cpu_rst, load_active, load_err;
  logic [7:0]  imem_addr;
  logic [23:0] imem_wdata;
  logic [8:0]  word_count;

  logic        s_imem_we, s_cpu_hold, s_cpu_rst, s_load_active, s_load_err;
  logic [1:0]  s_imem_addr;
  logic [23:0] s_imem_wdata;
  logic [2:0]  s_word_count;

  uart_prog_loader #(.ADDR_W(8), .RST_PULSE_CYCLES(16), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .cpu_rst(cpu_rst), .load_active(load_active),
    .word_count(word_count), .load_err(load_err)
  );

  uart_prog_loader #(.ADDR_W(2), .RST_PULSE_CYCLES(16)) dut_small (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
    .cpu_hold(s_cpu_hold), .cpu_rst(s_cpu_rst), .load_active(s_load_active),
    .word_count(s_word_count), .load_err(s_load_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit chk_small = 1'b0;

  typedef struct {
    int          addr;
    logic [23:0] data;
    int          cyc;
  } exp_t;

  exp_t q_big[$];
  exp_t q_small[$];

  always @(negedge clk) begin
    if (imem_we) begin
      checks++;
      if (q_big.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got addr=%0d data=%h, expected no write", imem_addr, imem_wdata);
      end else begin
        exp_t e;
        e = q_big.pop_front();
        if (imem_addr !== 8'(e.addr) || imem_wdata !== e.data || cyc !== e.cyc) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%h cyc=%0d, expected addr=%0d data=%h cyc=%0d",
                   imem_addr, imem_wdata, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_small && s_imem_we) begin
      checks++;
      if (q_small.size() == 0) begin
        errors++;
        $display("FAIL small_write_unexpected: got addr=%0d data=%h, expected no write", s_imem_addr, s_imem_wdata);
      end else begin
        exp_t e;
        e = q_small.pop_front();
        if (s_imem_addr !== 2'(e.addr) || s_imem_wdata !== e.data || cyc !== e.cyc) begin
          errors++;
          $display("FAIL small_write: got addr=%0d data=%h cyc=%0d, expected addr=%0d data=%h cyc=%0d",
                   s_imem_addr, s_imem_wdata, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // The write for a word is expected the cycle after its third byte is sampled.
  task automatic send_word(input logic [23:0] w, input int gap, input bit exp_big,
                           input bit exp_small, input int addr);
    drive_byte(w[7:0]);
    idle(gap);
    drive_byte(w[15:8]);
    idle(gap);
    if (exp_big)   q_big.push_back('{addr: addr, data: w, cyc: cyc + 1});
    if (exp_small) q_small.push_back('{addr: addr, data: w, cyc: cyc + 1});
    drive_byte(w[23:16]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic measure_pulse(output int n);
    n = 0;
    while (cpu_rst === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    idle(2);
    checks++;
    if ({imem_we, imem_addr, imem_wdata, word_count} !== '0) begin
      errors++;
      $display("FAIL reset_imem: got we=%b addr=%h data=%h wc=%0d, expected all 0",
               imem_we, imem_addr, imem_wdata, word_count);
    end
    checks++;
    if ({cpu_hold, cpu_rst, load_active, load_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got hold/rst/active/err=%b, expected 0000",
               {cpu_hold, cpu_rst, load_active, load_err});
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_basic_load();
    int n;
    do_reset();
    send_word(24'hFF0000, 1, 1'b0, 1'b0, 0);
    checks++;
    if ({load_active, cpu_hold} !== 2'b11) begin
      errors++;
      $display("FAIL basic_start: got active/hold=%b, expected 11", {load_active, cpu_hold});
    end
    send_word(24'h80010A, 1, 1'b1, 1'b0, 0);
    send_word(24'h800214, 1, 1'b1, 1'b0, 1);
    send_word(24'hFFFF00, 1, 1'b0, 1'b0, 0);
    checks++;
    if ({cpu_hold, load_active} !== 2'b00) begin
      errors++;
      $display("FAIL basic_release: got hold/active=%b, expected 00", {cpu_hold, load_active});
    end
    measure_pulse(n);
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL basic_pulse_width: got %0d cycles, expected 16", n);
    end
    checks++;
    if (word_count !== 9'd2 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_count: got wc=%0d err=%b, expected wc=2 err=0", word_count, load_err);
    end
  endtask

  task automatic test_sliding_stop_hold();
    int n;
    do_reset();
    drive_byte(8'h37);
    send_word(24'hFF0000, 0, 1'b0, 1'b0, 0);
    checks++;
    if (load_active !== 1'b1) begin
      errors++;
      $display("FAIL sliding_sync: got load_active=%b, expected 1", load_active);
    end
    send_word(24'h800405, 0, 1'b1, 1'b0, 0);
    send_word(24'hFFFF01, 0, 1'b0, 1'b0, 0);
    n = 0;
    repeat (40) begin
      if (cpu_rst !== 1'b0) n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 0 || cpu_hold !== 1'b1 || load_active !== 1'b0 || word_count !== 9'd1) begin
      errors++;
      $display("FAIL stop_hold: got rst_cycles=%0d hold=%b active=%b wc=%0d, expected 0 1 0 1",
               n, cpu_hold, load_active, word_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    chk_small = 1'b1;
    send_word(24'hFF0000, 0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++)
      send_word(24'h500000 + 24'(i * 17), 0, 1'b1, (i < 4), i);
    send_word(24'hFFFF00, 0, 1'b0, 1'b0, 0);
    checks++;
    if (s_word_count !== 3'd4 || s_load_err !== 1'b1 || s_imem_addr !== 2'd3) begin
      errors++;
      $display("FAIL overflow_small: got wc=%0d err=%b addr=%0d, expected wc=4 err=1 addr=3",
               s_word_count, s_load_err, s_imem_addr);
    end
    checks++;
    if (word_count !== 9'd5 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL overflow_big: got wc=%0d err=%b, expected wc=5 err=0", word_count, load_err);
    end
    idle(2);
    chk_small = 1'b0;
  endtask

  task automatic test_restart();
    do_reset();
    send_word(24'hFF0000, 0, 1'b0, 1'b0, 0);
    send_word(24'h111111, 0, 1'b1, 1'b0, 0);
    send_word(24'h222222, 0, 1'b1, 1'b0, 1);
    send_word(24'hFF0000, 0, 1'b0, 1'b0, 0);
    checks++;
    if (word_count !== 9'd0 || load_active !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear: got wc=%0d active=%b, expected 0 1", word_count, load_active);
    end
    send_word(24'hD400FD, 0, 1'b1, 1'b0, 0);
    send_word(24'hFFFF00, 0, 1'b0, 1'b0, 0);
    checks++;
    if (word_count !== 9'd1) begin
      errors++;
      $display("FAIL restart_count: got wc=%0d, expected 1", word_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_word(24'hFF0000, 0, 1'b0, 1'b0, 0);
    send_word(24'h000000, 0, 1'b1, 1'b0, 0);
    send_word(24'hFF00FD, 0, 1'b1, 1'b0, 1);
    send_word(24'hFFFF02, 0, 1'b1, 1'b0, 2);
    send_word(24'h123456, 0, 1'b1, 1'b0, 3);
    send_word(24'hFFFF00, 0, 1'b0, 1'b0, 0);
    checks++;
    if (word_count !== 9'd4) begin
      errors++;
      $display("FAIL b2b_count: got wc=%0d, expected 4", word_count);
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    send_word(24'hFF0000, 0, 1'b0, 1'b0, 0);
    drive_byte(8'h11);
    drive_byte(8'h22);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({load_active, cpu_hold} !== 2'b00) begin
      errors++;
      $display("FAIL async_reset: got active/hold=%b, expected 00", {load_active, cpu_hold});
    end
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    send_word(24'hFF0000, 0, 1'b0, 1'b0, 0);
    send_word(24'h031300, 0, 1'b1, 1'b0, 0);
    send_word(24'hFFFF00, 0, 1'b0, 1'b0, 0);
    checks++;
    if (word_count !== 9'd1) begin
      errors++;
      $display("FAIL reset_mid_count: got wc=%0d, expected 1", word_count);
    end
  endtask

  task automatic test_abort_pulse();
    int n;
    do_reset();
    send_word(24'hFF0000, 0, 1'b0, 1'b0, 0);
    send_word(24'hABCDEF, 0, 1'b1, 1'b0, 0);
    send_word(24'hFFFF00, 0, 1'b0, 1'b0, 0);
    idle(2);
    send_word(24'hFF0000, 0, 1'b0, 1'b0, 0);
    checks++;
    if ({cpu_rst, cpu_hold, load_active} !== 3'b011 || word_count !== 9'd0) begin
      errors++;
      $display("FAIL abort_pulse: got rst/hold/active=%b wc=%0d, expected 011 wc=0",
               {cpu_rst, cpu_hold, load_active}, word_count);
    end
    send_word(24'hFFFF00, 0, 1'b0, 1'b0, 0);
    measure_pulse(n);
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL abort_repulse: got %0d cycles, expected 16", n);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send_word(24'hFF0000, 0, 1'b0, 1'b0, 0);
    drive_byte(8'h0A);
    drive_byte(8'h01);
    idle(2000);
`ifdef LOADER_TIMEOUT_EN
    checks++;
    if (load_err !== 1'b1 || load_active !== 1'b1) begin
      errors++;
      $display("FAIL timeout_flag: got err=%b active=%b, expected 1 1", load_err, load_active);
    end
    send_word(24'h800632, 0, 1'b1, 1'b0, 0);
`else
    checks++;
    if (load_err !== 1'b0 || load_active !== 1'b1) begin
      errors++;
      $display("FAIL no_timeout_flag: got err=%b active=%b, expected 0 1", load_err, load_active);
    end
    q_big.push_back('{addr: 0, data: 24'h32010A, cyc: cyc + 1});
    drive_byte(8'h32);
    drive_byte(8'h06);
    drive_byte(8'h80);
`endif
    idle(2);
    checks++;
    if (word_count !== 9'd1) begin
      errors++;
      $display("FAIL timeout_count: got wc=%0d, expected 1", word_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_sliding_stop_hold();
    test_overflow();
    test_restart();
    test_back_to_back();
    test_reset_mid_load();
    test_abort_pulse();
    test_timeout();
    idle(4);
    checks++;
    if (q_big.size() != 0 || q_small.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained: got %0d/%0d pending writes, expected 0/0",
               q_big.size(), q_small.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
